// File: rtl/sram_pkg.sv
// Shared types and default sizing for the asynchronous SRAM controller.
// The top module imports this package.
package sram_pkg;

  localparam int DEF_ADDR_WIDTH = 20;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_READ_WAIT  = 2;
  localparam int DEF_WRITE_WAIT = 2;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    HOLD
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Single-request controller for an asynchronous SRAM. Every strobe is registered,
// and the data pad is only driven during the write and data-hold phases.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int READ_WAIT  = DEF_READ_WAIT,
  parameter int WRITE_WAIT = DEF_WRITE_WAIT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    ready,
  output logic                    done,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [ADDR_WIDTH-1:0]   dev_addr,
  inout  wire  [DATA_WIDTH-1:0]   dev_data,
  output logic                    dev_ce,
  output logic                    dev_oe,
  output logic                    dev_we,
  output logic [DATA_WIDTH/8-1:0] dev_be
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(max_int(READ_WAIT, WRITE_WAIT) + 1);

  state_e                state;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  drive_en;

  assign ready    = (state == IDLE);
  assign dev_data = drive_en ? wdata_q : 'z;

  // NOTE: sequential state uses non-blocking assignments so every register
  // in this block samples the pre-edge value of every other one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      done     <= 1'b0;
      rdata    <= '0;
      dev_addr <= '0;
      dev_ce   <= 1'b1;
      dev_oe   <= 1'b1;
      dev_we   <= 1'b1;
      dev_be   <= '1;
      drive_en <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            dev_addr <= req_addr;
            wdata_q  <= req_wdata;
            dev_ce   <= 1'b0;
            if (req_we) begin
              state    <= WRITE;
              cnt      <= CNT_W'(WRITE_WAIT - 1);
              dev_we   <= 1'b0;
              dev_be   <= ~req_be;
              drive_en <= 1'b1;
            end else begin
              state  <= READ;
              cnt    <= CNT_W'(READ_WAIT - 1);
              dev_oe <= 1'b0;
              dev_be <= {BE_W{1'b0}};
            end
          end
        end
        READ: begin
          if (cnt == '0) begin
            rdata  <= dev_data;
            state  <= IDLE;
            done   <= 1'b1;
            dev_ce <= 1'b1;
            dev_oe <= 1'b1;
            dev_be <= '1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        WRITE: begin
          // WE rises one cycle before the pad is released to give data hold time.
          if (cnt == '0) begin
            state  <= HOLD;
            dev_we <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        HOLD: begin
          state    <= IDLE;
          done     <= 1'b1;
          dev_ce   <= 1'b1;
          dev_be   <= '1;
          drive_en <= 1'b0;
        end
      endcase
    end
  end

endmodule
